// File: rtl/if_fetch_unit_pkg.sv
// Shared constants for the fetch stage: stall-bus encoding, pipeline bus widths
// and the reset PC, plus the redirect-hold FSM state type.
package if_fetch_unit_pkg;

    localparam int StallBus    = 6;
    localparam int IF_TO_ID_WD = 33;
    localparam int BR_WD       = 33;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // One word before the boot vector, so the first increment lands on bfc0_0000.
    localparam logic [31:0] ResetPC = 32'hbfbf_fffc;

    typedef enum logic {
        REDIR_IDLE = 1'b0,
        REDIR_HOLD = 1'b1
    } redir_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage pipeline and instruction-SRAM signals; master is the fetch unit,
// slave is the decode stage / memory side that drives it.
interface if_fetch_unit_if import if_fetch_unit_pkg::*;;

    logic [StallBus-1:0]    stall;
    logic                   flush;
    logic [31:0]            new_pc;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;

    modport master (
        input  stall, flush, new_pc, br_bus,
        output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output stall, flush, new_pc, br_bus,
        input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
    );

endinterface

// File: rtl/if_fetch_unit_pc_redirect_hold.sv
// Remembers the first branch redirect seen while the PC is stalled and offers it
// as the next PC once the stall lifts; flush or reset discards it.
module pc_redirect_hold import if_fetch_unit_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_e,
    input  logic [31:0] br_addr,
    input  logic        stall0,
    input  logic        flush,
    output logic        pend_v,
    output logic [31:0] pend_addr
);

    redir_state_e state_q, state_d;
    logic         capture;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (flush || stall0 == NoStop) begin
            state_d = REDIR_IDLE;
        end else if (state_q == REDIR_IDLE && br_e) begin
            // Only the first redirect counts; decode re-asserts the same branch while stalled.
            state_d = REDIR_HOLD;
            capture = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REDIR_IDLE;
            pend_addr <= 32'h0;
        end else begin
            state_q <= state_d;
            if (capture) pend_addr <= br_addr;
        end
    end

    assign pend_v = (state_q == REDIR_HOLD);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues the instruction-SRAM read and
// hands {ce, pc} to decode, honouring flush, held branch and branch redirects.
module if_fetch_unit import if_fetch_unit_pkg::*; #(
    parameter logic [31:0] RESET_PC = ResetPC
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_unit_if.master bus
);

    logic [31:0] pc_reg;
    logic        ce_reg;
    logic [31:0] next_pc;
    logic        br_e;
    logic [31:0] br_addr;
    logic        stall0;
    logic        pend_v;
    logic [31:0] pend_addr;
    logic        unused_stall_hi;

    assign stall0  = bus.stall[0];
    // A branch from decode is meaningless before the first real fetch.
    assign br_e    = bus.br_bus[32] & ce_reg;
    assign br_addr = bus.br_bus[31:0];
    assign unused_stall_hi = ^bus.stall[StallBus-1:1];

    pc_redirect_hold u_hold (
        .clk       (clk),
        .rst       (rst),
        .br_e      (br_e),
        .br_addr   (br_addr),
        .stall0    (stall0),
        .flush     (bus.flush),
        .pend_v    (pend_v),
        .pend_addr (pend_addr)
    );

    always_comb begin
        next_pc = pc_reg + 32'd4;
        if (bus.flush)  next_pc = bus.new_pc;
        else if (pend_v) next_pc = pend_addr;
        else if (br_e)   next_pc = br_addr;
    end

    // Flush overrides the stall so exception entry is never delayed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
            ce_reg <= 1'b0;
        end else if (bus.flush || stall0 == NoStop) begin
            pc_reg <= next_pc;
            ce_reg <= 1'b1;
        end
    end

    assign bus.if_to_id_bus    = {ce_reg, pc_reg};
    assign bus.inst_sram_en    = ce_reg;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = pc_reg;
    assign bus.inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, sequential fetch, branch, stalled
// branch hold, flush over a held branch, PC wrap and reset during hold.
module tb_if_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    if_fetch_unit_if bus ();

    if_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Advance one clock and sample #1 after the edge; inputs change only here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic stall0, input logic br_e, input logic [31:0] br_addr,
                         input logic flush, input logic [31:0] new_pc);
        bus.stall  = {5'b0, stall0};
        bus.br_bus = {br_e, br_addr};
        bus.flush  = flush;
        bus.new_pc = new_pc;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [3] = '{32'hbfc0_0000, 32'hbfc0_0004, 32'hbfc0_0008};
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) step();
        n_vec++;
        if (bus.if_to_id_bus !== {1'b0, 32'hbfbf_fffc} || bus.inst_sram_en !== 1'b0 ||
            bus.inst_sram_wen !== 4'b0 || bus.inst_sram_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: bus=%h en=%b wen=%h wdata=%h, want bus=0bfbffffc en=0 wen=0 wdata=0",
                     bus.if_to_id_bus, bus.inst_sram_en, bus.inst_sram_wen, bus.inst_sram_wdata);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (bus.if_to_id_bus !== {1'b1, exp_pc[i]} || bus.inst_sram_addr !== exp_pc[i] ||
                bus.inst_sram_en !== 1'b1 || bus.inst_sram_wen !== 4'b0) begin
                n_err++;
                $display("FAIL seq_fetch[%0d]: bus=%h addr=%h en=%b wen=%h, want pc=%h ce=1",
                         i, bus.if_to_id_bus, bus.inst_sram_addr, bus.inst_sram_en,
                         bus.inst_sram_wen, exp_pc[i]);
            end
        end
    endtask

    task automatic test_branch();
        drive(1'b0, 1'b1, 32'hbfc0_0100, 1'b0, 32'h0);
        step();
        n_vec++;
        if (bus.if_to_id_bus !== {1'b1, 32'hbfc0_0100}) begin
            n_err++;
            $display("FAIL branch_target: bus=%h want 1bfc00100", bus.if_to_id_bus);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        n_vec++;
        if (bus.if_to_id_bus !== {1'b1, 32'hbfc0_0104}) begin
            n_err++;
            $display("FAIL branch_after: bus=%h want 1bfc00104", bus.if_to_id_bus);
        end
    endtask

    task automatic test_stall_hold();
        logic [31:0] br_tbl [3] = '{32'hbfc0_0200, 32'hbfc0_0300, 32'h0};
        logic        be_tbl [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, be_tbl[i], br_tbl[i], 1'b0, 32'h0);
            step();
            n_vec++;
            if (bus.if_to_id_bus !== {1'b1, 32'hbfc0_0104}) begin
                n_err++;
                $display("FAIL stall_frozen[%0d]: bus=%h want 1bfc00104", i, bus.if_to_id_bus);
            end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        n_vec++;
        if (bus.if_to_id_bus !== {1'b1, 32'hbfc0_0200}) begin
            n_err++;
            $display("FAIL stall_release: bus=%h want 1bfc00200 (first branch kept)", bus.if_to_id_bus);
        end
        step();
        n_vec++;
        if (bus.if_to_id_bus !== {1'b1, 32'hbfc0_0204}) begin
            n_err++;
            $display("FAIL pend_cleared: bus=%h want 1bfc00204", bus.if_to_id_bus);
        end
    endtask

    task automatic test_flush_over_pend();
        logic [31:0] exp_pc [4] = '{32'hbfc0_0380, 32'hbfc0_0380, 32'hbfc0_0384, 32'hbfc0_0388};
        logic        stl    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        drive(1'b1, 1'b1, 32'hbfc0_0500, 1'b0, 32'h0);
        step();
        n_vec++;
        if (bus.if_to_id_bus !== {1'b1, 32'hbfc0_0204}) begin
            n_err++;
            $display("FAIL flush_prestall: bus=%h want 1bfc00204", bus.if_to_id_bus);
        end
        for (int i = 0; i < 4; i++) begin
            drive(stl[i], 1'b0, 32'h0, (i == 0), 32'hbfc0_0380);
            step();
            n_vec++;
            if (bus.if_to_id_bus !== {1'b1, exp_pc[i]}) begin
                n_err++;
                $display("FAIL flush_seq[%0d]: bus=%h want pc=%h ce=1", i, bus.if_to_id_bus, exp_pc[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3] = '{32'hffff_fffc, 32'h0000_0000, 32'h0000_0004};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, (i == 0), 32'hffff_fffc);
            step();
            n_vec++;
            if (bus.if_to_id_bus !== {1'b1, exp_pc[i]}) begin
                n_err++;
                $display("FAIL wrap[%0d]: bus=%h want pc=%h ce=1", i, bus.if_to_id_bus, exp_pc[i]);
            end
        end
    endtask

    task automatic test_reset_in_hold();
        drive(1'b1, 1'b1, 32'hbfc0_0200, 1'b0, 32'h0);
        step();
        n_vec++;
        if (bus.if_to_id_bus !== {1'b1, 32'h0000_0004}) begin
            n_err++;
            $display("FAIL hold_entry: bus=%h want 100000004", bus.if_to_id_bus);
        end
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        n_vec++;
        if (bus.if_to_id_bus !== {1'b0, 32'hbfbf_fffc} || bus.inst_sram_en !== 1'b0) begin
            n_err++;
            $display("FAIL rst_in_hold: bus=%h en=%b want 0bfbffffc en=0", bus.if_to_id_bus, bus.inst_sram_en);
        end
        // Stalled right after reset with a stray branch: ce=0 must mask it.
        rst = 1'b0;
        drive(1'b1, 1'b1, 32'hbfc0_0700, 1'b0, 32'h0);
        step();
        n_vec++;
        if (bus.if_to_id_bus !== {1'b0, 32'hbfbf_fffc}) begin
            n_err++;
            $display("FAIL post_rst_stall: bus=%h want 0bfbffffc", bus.if_to_id_bus);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        n_vec++;
        if (bus.if_to_id_bus !== {1'b1, 32'hbfc0_0000}) begin
            n_err++;
            $display("FAIL post_rst_fetch: bus=%h want 1bfc00000 (no redirect)", bus.if_to_id_bus);
        end
        step();
        n_vec++;
        if (bus.if_to_id_bus !== {1'b1, 32'hbfc0_0004}) begin
            n_err++;
            $display("FAIL post_rst_next: bus=%h want 1bfc00004", bus.if_to_id_bus);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall_hold();
        test_flush_over_pend();
        test_wrap();
        test_reset_in_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC register and drives the instruction SRAM request. Produces `if_to_id_bus` for the decode stage, which latches it and reads the returned instruction word one cycle later. Consumes the decode stage's `br_bus` branch redirect and keeps any redirect that arrives while the PC is stalled, so the redirect is never lost.

## Interface
Parameters:
- `RESET_PC`, default 32'hbfbf_fffc: PC value held during reset. The first fetched address is `RESET_PC`+4 = 32'hbfc0_0000.

Ports:
- `clk`  in  1  single pipeline clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `stall`  in  `StallBus` (6)  per-stage stall vector. Bit 0 (`Stop`=1, `NoStop`=0) freezes the PC.
- `flush`  in  1  exception/ERET redirect request.
- `new_pc`  in  32  flush target address.
- `br_bus`  in  `BR_WD` (33)  {`br_e`, `br_addr[31:0]`} from decode, combinational, same cycle.
- `if_to_id_bus`  out  `IF_TO_ID_WD` (33)  {`ce`, `pc[31:0]`}.
- `inst_sram_en`  out  1  fetch request, equal to `ce`.
- `inst_sram_wen`  out  4  constant 4'b0000.
- `inst_sram_addr`  out  32  equal to `pc`.
- `inst_sram_wdata`  out  32  constant 32'h0.

## Operation
- Registers: `pc_reg[31:0]`, `ce_reg`, `pend_v`, `pend_addr[31:0]`.
- Two-state redirect FSM:
  - IDLE (`pend_v`=0).
  - HOLD (`pend_v`=1, a branch target is waiting).
- Next-PC select, highest priority first:
  - `flush` selects `new_pc`.
  - `pend_v` selects `pend_addr`.
  - `br_e` selects `br_addr`.
  - Otherwise `pc_reg`+4, wrapping modulo 2^32.
- Update at each rising edge, in priority order:
  - `rst`: `pc_reg`←`RESET_PC`, `ce_reg`←0, `pend_v`←0, `pend_addr`←0.
  - `flush`: `pc_reg`←`new_pc`, `ce_reg`←1, `pend_v`←0. Applies even when `stall[0]`=`Stop`.
  - `stall[0]`=`NoStop`: `pc_reg`←next-PC, `ce_reg`←1, `pend_v`←0 (HOLD goes to IDLE).
  - `stall[0]`=`Stop` and `br_e`=1 and `pend_v`=0: `pend_v`←1, `pend_addr`←`br_addr` (IDLE goes to HOLD). `pc_reg` and `ce_reg` hold.
  - `stall[0]`=`Stop` otherwise: all registers hold. A repeated `br_e` while in HOLD (decode re-evaluating the same stalled branch) does not overwrite `pend_addr`.
- `br_e` is ignored while `ce_reg`=0. After reset, decode's bus is zero, so this case is only a guard.
- No alignment check is performed here; `pc` is passed through as stored.

## Timing
- Combinational outputs, driven purely from registers:
  - `if_to_id_bus` = {`ce_reg`, `pc_reg`}.
  - `inst_sram_en` = `ce_reg`.
  - `inst_sram_addr` = `pc_reg`.
- Reset values: `if_to_id_bus` = {0, 32'hbfbf_fffc}, `inst_sram_en`=0, `wen`=0, `wdata`=0.
- First cycle after `rst` drops: `pc`=32'hbfc0_0000, `ce`=1, provided `stall[0]`=`NoStop`.
- Branch redirect latency is one cycle. `br_e` seen in cycle N with no stall gives `pc`=`br_addr` in cycle N+1. The instruction already in IF in cycle N is the delay slot and proceeds normally.
- Redirect during a stall: `pc`=`pend_addr` in the first cycle after `stall[0]` returns to `NoStop`.
- Flush latency is one cycle regardless of stall. Flush discards any pending branch.
- `rst` during HOLD clears the pending branch; no redirect survives reset.

## Structure
- Shared package `lib/defines.vh` supplies `StallBus`, `Stop`, `NoStop`, `IF_TO_ID_WD`, `BR_WD`. The reset-PC constant is added there as `ResetPC`.
- One sub-module is natural: `pc_redirect_hold`, containing the two-state FSM plus `pend_addr`, with inputs `br_e`, `br_addr`, `stall0`, `flush`, `rst`. Everything else is inline in `if_fetch_unit`.

## Test plan
- Reset for 3 cycles, then release with no stall → cycle 0 shows `pc`=bfbf_fffc, `ce`=0; the following cycles show `pc`=bfc0_0000, bfc0_0004, bfc0_0008 with `ce`=1 and `wen`=0.
- `br_e`=1, `br_addr`=bfc0_0100 at `pc`=bfc0_0008 with no stall → next cycle `pc`=bfc0_0100, then bfc0_0104.
- `stall[0]`=`Stop` for 3 cycles with `br_e`=1, `br_addr`=bfc0_0200 in the first cycle and `br_addr`=bfc0_0300 in the second → `pc` is frozen during the stall; on release `pc`=bfc0_0200 and `pend_v`=0.
- Pending bfc0_0200 plus `flush`=1, `new_pc`=bfc0_0380 while still stalled → next cycle `pc`=bfc0_0380; after release `pc` runs bfc0_0384, with no jump to bfc0_0200.
- `pc_reg`=ffff_fffc with no stall → next `pc`=0000_0000 (wrap).
- `rst` asserted while in HOLD with `pend_addr`=bfc0_0200 → `pc`=bfbf_fffc, `ce`=0; after release `pc`=bfc0_0000, with no redirect.
